// File: rtl/cdb_broadcaster.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_broadcaster
//  Purpose  : Common data bus result broadcaster. Each functional unit hands
//             over a completed result (tag + value) into its own one-entry
//             holding slot; a round-robin arbiter picks one full slot per
//             clock and broadcasts it on the registered CDB outputs.
//             Tag 0 means "not redirected": such offers are accepted,
//             dropped, and flagged on tag_error for one cycle.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_SRC    number of functional-unit sources (2..8)
//    DATA_W     result value width
//    TAG_W      reservation-station tag width
//  Ports
//    clock        in   single clock, posedge
//    reset_n      in   asynchronous active-low reset
//    src_valid    in   [NUM_SRC]          per-source result offer
//    src_ready    out  [NUM_SRC]          per-source accept (combinational)
//    src_tag      in   [NUM_SRC*TAG_W]    packed tags, source i at i*TAG_W
//    src_data     in   [NUM_SRC*DATA_W]   packed values, source i at i*DATA_W
//    cdb_write    out  broadcast strobe (registered)
//    cdb_source   out  [TAG_W]  broadcast tag (registered)
//    cdb_data     out  [DATA_W] broadcast value (registered, holds when idle)
//    tag_error    out  one-cycle pulse after a zero-tag offer was discarded
//  Build option
//    CDB_STATS_EN  adds stat_bcast[31:0] (cycles with cdb_write=1) and
//                  stat_stall[31:0] (cycles with a valid but unready source)
// ============================================================================
module cdb_broadcaster #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      cdb_write,
  output logic [TAG_W-1:0]          cdb_source,
  output logic [DATA_W-1:0]         cdb_data,
  output logic                      tag_error
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]               stat_bcast,
  output logic [31:0]               stat_stall
`endif
);

  localparam int             PTR_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W:0] NUM_SRC_EXT = (PTR_W + 1)'(NUM_SRC);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_SRC - 1);

  // Holding slots
  logic [NUM_SRC-1:0] full_q, full_d;
  logic [TAG_W-1:0]   tag_q  [NUM_SRC];
  logic [TAG_W-1:0]   tag_d  [NUM_SRC];
  logic [DATA_W-1:0]  data_q [NUM_SRC];
  logic [DATA_W-1:0]  data_d [NUM_SRC];

  // Arbiter and broadcast registers
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_write_q, cdb_write_d;
  logic [TAG_W-1:0]   cdb_source_q, cdb_source_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic               tag_error_q, tag_error_d;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;
  logic               any_grant;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W:0]     cand;
  logic               zero_hit;

  // --------------------------------------------------------------------------
  // Round-robin pick: scan from rr_ptr upward, wrapping, first full slot wins.
  // The candidate index is kept one bit wider so the wrap is a plain subtract
  // and works for NUM_SRC values that are not a power of two.
  // --------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (cand >= NUM_SRC_EXT) begin
        cand = cand - NUM_SRC_EXT;
      end
      if (!any_grant && full_q[cand[PTR_W-1:0]]) begin
        any_grant = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
    if (any_grant) begin
      grant[win_idx] = 1'b1;
    end
  end

  // A slot being drained this cycle may be refilled on the same edge.
  assign src_ready = ~full_q | grant;
  assign accept    = src_valid & src_ready;

  // --------------------------------------------------------------------------
  // Slot update: the drain clears full, a capture on the same edge sets it
  // again. The broadcast below reads tag_q/data_q, so the old result goes out
  // while the new one is stored.
  // --------------------------------------------------------------------------
  always_comb begin
    full_d   = full_q & ~grant;
    tag_d    = tag_q;
    data_d   = data_q;
    zero_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        if (src_tag[i*TAG_W +: TAG_W] != '0) begin
          full_d[i] = 1'b1;
          tag_d[i]  = src_tag[i*TAG_W +: TAG_W];
          data_d[i] = src_data[i*DATA_W +: DATA_W];
        end else begin
          zero_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cdb_write_d  = any_grant;
    cdb_source_d = any_grant ? tag_q[win_idx] : '0;
    cdb_data_d   = any_grant ? data_q[win_idx] : cdb_data_q;
    tag_error_d  = zero_hit;
    rr_ptr_d     = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q       <= '0;
      rr_ptr_q     <= '0;
      cdb_write_q  <= 1'b0;
      cdb_source_q <= '0;
      cdb_data_q   <= '0;
      tag_error_q  <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      full_q       <= full_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_write_q  <= cdb_write_d;
      cdb_source_q <= cdb_source_d;
      cdb_data_q   <= cdb_data_d;
      tag_error_q  <= tag_error_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign cdb_write  = cdb_write_q;
  assign cdb_source = cdb_source_q;
  assign cdb_data   = cdb_data_q;
  assign tag_error  = tag_error_q;

`ifdef CDB_STATS_EN
  // Free-running statistics, wrapping naturally at 2^32.
  logic [31:0] stat_bcast_q, stat_bcast_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_bcast_d = stat_bcast_q + {31'd0, cdb_write_q};
    stat_stall_d = stat_stall_q + {31'd0, |(src_valid & ~src_ready)};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_bcast_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_bcast_q <= stat_bcast_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_bcast = stat_bcast_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_broadcaster.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_broadcaster
//  Purpose  : Directed self-checking bench for cdb_broadcaster (4 sources,
//             32-bit data, 6-bit tags).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cdb_broadcaster;

  logic         clock;
  logic         reset_n;
  logic [3:0]   src_valid;
  logic [3:0]   src_ready;
  logic [23:0]  src_tag;
  logic [127:0] src_data;
  logic         cdb_write;
  logic [5:0]   cdb_source;
  logic [31:0]  cdb_data;
  logic         tag_error;
`ifdef CDB_STATS_EN
  logic [31:0]  stat_bcast;
  logic [31:0]  stat_stall;
`endif

  int total = 0;
  int bad   = 0;

  cdb_broadcaster #(
    .NUM_SRC (4),
    .DATA_W  (32),
    .TAG_W   (6)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_tag    (src_tag),
    .src_data   (src_data),
    .cdb_write  (cdb_write),
    .cdb_source (cdb_source),
    .cdb_data   (cdb_data),
    .tag_error  (tag_error)
`ifdef CDB_STATS_EN
    ,
    .stat_bcast (stat_bcast),
    .stat_stall (stat_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [5:0] t, input logic [31:0] d);
    src_tag[i*6 +: 6]    = t;
    src_data[i*32 +: 32] = d;
  endtask

  initial begin
    int         seq [4];
    logic [3:0] acc;

    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    // ---------------- reset state ----------------
    chk("rst_write",  32'(cdb_write),  32'd0);
    chk("rst_source", 32'(cdb_source), 32'd0);
    chk("rst_data",   cdb_data,        32'd0);
    chk("rst_tagerr", 32'(tag_error),  32'd0);
    chk("rst_ready",  32'(src_ready),  32'hF);
    #9 reset_n = 1'b1;            // t=12, before the edge at 15

    // ---------------- single offer ----------------
    src_valid = 4'b0001;
    set_src(0, 6'd5, 32'hDEAD);
    tick();                        // capture edge
    src_valid = '0;
    chk("single_nowrite_capture", 32'(cdb_write), 32'd0);
    tick();                        // broadcast edge
    chk("single_write",  32'(cdb_write),  32'd1);
    chk("single_source", 32'(cdb_source), 32'd5);
    chk("single_data",   cdb_data,        32'hDEAD);
    tick();
    chk("single_write_off",  32'(cdb_write),  32'd0);
    chk("single_source_off", 32'(cdb_source), 32'd0);
    chk("single_data_hold",  cdb_data,        32'hDEAD);

    // ---------------- zero tag ----------------
    src_valid = 4'b0100;
    set_src(2, 6'd0, 32'h1234);
    chk("zero_ready", 32'(src_ready[2]), 32'd1);
    tick();
    src_valid = '0;
    chk("zero_tagerr_hi", 32'(tag_error), 32'd1);
    chk("zero_nowrite",   32'(cdb_write), 32'd0);
    tick();
    chk("zero_tagerr_lo",  32'(tag_error), 32'd0);
    chk("zero_nobcast",    32'(cdb_write), 32'd0);
    chk("zero_ready_idle", 32'(src_ready), 32'hF);

    // ---------------- reset mid-operation ----------------
    // rr_ptr is 1 after the grant to source 0 above.
    src_valid = 4'b1011;
    set_src(0, 6'd7, 32'h70);
    set_src(1, 6'd8, 32'h80);
    set_src(3, 6'd9, 32'h90);
    tick();
    src_valid = '0;
    chk("mid_ready_full", 32'(src_ready), 32'b0100 | 32'b0010);
    tick();
    chk("mid_rr_source", 32'(cdb_source), 32'd8);
    chk("mid_rr_data",   cdb_data,        32'h80);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_write",  32'(cdb_write),  32'd0);
    chk("mid_rst_source", 32'(cdb_source), 32'd0);
    chk("mid_rst_data",   cdb_data,        32'd0);
    chk("mid_rst_ready",  32'(src_ready),  32'hF);
    #1 reset_n = 1'b1;
    tick();
    chk("mid_no_stale0", 32'(cdb_write), 32'd0);
    tick();
    chk("mid_no_stale1", 32'(cdb_write), 32'd0);
`ifdef CDB_STATS_EN
    chk("stat_bcast_rst", stat_bcast, 32'd0);
    chk("stat_stall_rst", stat_stall, 32'd0);
`endif

    // ---------------- all four in one edge (rr_ptr=0 after reset) ----------------
    src_valid = 4'b1111;
    set_src(0, 6'd1, 32'h11);
    set_src(1, 6'd2, 32'h22);
    set_src(2, 6'd3, 32'h33);
    set_src(3, 6'd4, 32'h44);
    chk("all4_ready_pre", 32'(src_ready), 32'hF);
    tick();
    src_valid = '0;
    chk("all4_nowrite", 32'(cdb_write), 32'd0);
    chk("all4_ready0",  32'(src_ready), 32'b0001);
    tick();
    chk("all4_src_b1", 32'(cdb_source), 32'd1);
    chk("all4_dat_b1", cdb_data,        32'h11);
    chk("all4_ready1", 32'(src_ready),  32'b0011);
    tick();
    chk("all4_src_b2", 32'(cdb_source), 32'd2);
    chk("all4_ready2", 32'(src_ready),  32'b0111);
    tick();
    chk("all4_src_b3", 32'(cdb_source), 32'd3);
    chk("all4_ready3", 32'(src_ready),  32'b1111);
    tick();
    chk("all4_src_b4", 32'(cdb_source), 32'd4);
    chk("all4_dat_b4", cdb_data,        32'h44);
    chk("all4_wr_b4",  32'(cdb_write),  32'd1);
    tick();
    chk("all4_idle_write",  32'(cdb_write),  32'd0);
    chk("all4_idle_source", 32'(cdb_source), 32'd0);
    chk("all4_idle_data",   cdb_data,        32'h44);
`ifdef CDB_STATS_EN
    chk("stat_bcast_all4", stat_bcast, 32'd4);
    chk("stat_stall_all4", stat_stall, 32'd0);
`endif

    // ---------------- continuous offers: 16 broadcasts + drain of 4 ----------------
    // Each source's data carries (source<<8 | sequence); the sequence advances
    // only when the offer is taken, so the j-th broadcast of source i must
    // carry sequence j.
    for (int i = 0; i < 4; i++) begin
      seq[i] = 0;
      set_src(i, 6'(i + 1), (32'(i) << 8) | 32'(seq[i]));
    end
    src_valid = 4'b1111;
    acc = src_valid & src_ready;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) seq[i]++;
      set_src(i, 6'(i + 1), (32'(i) << 8) | 32'(seq[i]));
    end
    for (int k = 0; k < 20; k++) begin
      if (k >= 16) src_valid = '0;
      acc = src_valid & src_ready;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) seq[i]++;
        set_src(i, 6'(i + 1), (32'(i) << 8) | 32'(seq[i]));
      end
      chk($sformatf("cont_write_%0d", k),  32'(cdb_write),  32'd1);
      chk($sformatf("cont_source_%0d", k), 32'(cdb_source), 32'((k % 4) + 1));
      chk($sformatf("cont_data_%0d", k),   cdb_data,        (32'(k % 4) << 8) | 32'(k / 4));
    end
    tick();
    chk("cont_drained", 32'(cdb_write), 32'd0);

    // ---------------- backpressure on src1 with 0/2/3 kept full ----------------
    src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_src(i, 6'(i + 1), 32'hA0 + 32'(i));
    chk("bp_ready_pre", 32'(src_ready), 32'hF);
    tick();
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("bp_ready_%0d", j),  32'(src_ready),  32'(4'b0001 << (j % 4)));
      tick();
      chk($sformatf("bp_source_%0d", j), 32'(cdb_source), 32'((j % 4) + 1));
    end
`ifdef CDB_STATS_EN
    chk("stat_stall_bp", stat_stall, 32'd24);
`endif
    src_valid = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
